sa_inst_sequencer: RTL and testbench
====================================

// Module: sa_inst_sequencer
// PURPOSE
//  Instruction-burst generator in front of SYSTOLIC_ARRAY. It expands one command
//  (opcode, base address, length, stride, trailing gap) into a stream of
//  per-cycle instruction words {opcode, addr, operand}.
//  It pulls operands from a valid/ready stream for WRITE_DATA/WRITE_WEIGHT and
//  replaces hand-sequenced instruction loops with a parametrised hardware block.
// PARAMETERS
//  OPCODE_BITS   4    opcode field width
//  ADDR_BITS     8    UB/WB address field width; addresses wrap mod 2**ADDR_BITS
//  OPERAND_BITS  128  operand field width (16 x 8-bit lanes)
//  LEN_BITS      9    burst length counter width (max 2**ADDR_BITS instructions)
//  GAP_BITS      8    trailing IDLE gap counter width
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  reset        in   1          synchronous, active-high reset
//  cmd_valid    in   1          command offer
//  cmd_ready    out  1          high only in S_IDLE
//  cmd_opcode   in   OPCODE_BITS  opcode to repeat (0x1..0x8 legal)
//  cmd_addr     in   ADDR_BITS    first address
//  cmd_len      in   LEN_BITS     number of instructions to emit
//  cmd_stride   in   ADDR_BITS    address increment per instruction
//  cmd_gap      in   GAP_BITS     IDLE cycles after the last instruction
//  op_valid     in   1          operand offer
//  op_ready     out  1          operand accept
//  op_data      in   OPERAND_BITS operand word
//  instruction  out  OPCODE_BITS+ADDR_BITS+OPERAND_BITS  registered; [MSB:..]=opcode, then addr, then operand
//  busy         out  1          ~cmd_ready
//  done         out  1          one-cycle pulse at command completion
//  err          out  1          one-cycle pulse, coincident with done, for an illegal opcode
// BEHAVIOUR
//  Reset: instruction=0 (IDLE_INST), cmd_ready=1, busy/done/err/op_ready=0, counters=0.
//  FSM S_IDLE -> S_ISSUE -> [S_GAP] -> S_IDLE.
//  - S_IDLE: instruction loads IDLE_INST on every edge. On cmd_valid&cmd_ready, latch the cmd fields.
//    - len==0 or illegal opcode: stay in S_IDLE. done (and err if illegal) is high the next cycle.
//    - Otherwise go to S_ISSUE.
//  - S_ISSUE, non-write opcode: each edge loads {opcode, addr, 0}, addr+=stride, remaining-=1.
//  - S_ISSUE, write opcode (5, 6): op_ready=1.
//    - On op_valid, load {opcode, addr, op_data} and advance.
//    - Without op_valid, load IDLE_INST and do not advance (stall bubble).
//  - Latency: the first instruction is visible in the 2nd cycle after the accept edge. Each instruction
//    is held exactly 1 cycle.
//  - After the edge that loads the last instruction, go to S_GAP if gap!=0, else S_IDLE.
//  - S_GAP: loads IDLE_INST for exactly cmd_gap cycles, then go to S_IDLE.
//  - done is registered high in the first cycle cmd_ready is high again. A new command accepted in that
//    cycle is legal (one IDLE bubble between back-to-back bursts).
//  - Address arithmetic is modulo 2**ADDR_BITS; stride 0 repeats the same address.
//  - op_ready is never high outside S_ISSUE or for non-write opcodes. Operands are never consumed
//    during stall or gap cycles.
//  - Reset mid-burst: the command is dropped and no done/err is raised. instruction=0 on the next cycle.
// STRUCTURE
//  Package sa_isa_pkg: opcode localparams IDLE..ACCUMULATION (0x0..0x8), field widths and field
//  bit-range constants, and an is_write_op() function. Shared with SYSTOLIC_ARRAY decode.
//  Sub-module sa_addr_gen: loadable address/length counter with stride, wrap and last flag.
//  The FSM, gap counter and output register live in the top.
// TESTING
//  1. Assert reset 2 cycles -> instruction==0, cmd_ready=1, busy=0, done=0.
//  2. WRITE_DATA addr=0 len=256 stride=1 gap=0, op_data lane j = i-j, always valid
//     -> 256 consecutive words, opcode 5, addr 0..255, operands match, then a done pulse.
//  3. Same burst with op_valid low every 3rd cycle -> IDLE_INST bubbles only on those cycles;
//     addresses and operands have no gaps or duplicates; count=256.
//  4. LOAD_WEIGHT addr=0xFE len=4 stride=1 gap=2 -> addrs FE,FF,00,01, operand 0,
//     then 2 IDLE cycles, then done; op_ready stays 0 throughout.
//  5. len=0 opcode 3 -> done next cycle, err=0. Opcode 0xA len=5 -> no instructions, done=err=1.
//  6. Reset during instruction #10 of a WRITE_WEIGHT burst -> next cycle instruction=0,
//     cmd_ready=1, no done. A following MAT_MUL addr=0 len=4 emits addrs 0..3 correctly.

Source files
------------

// File: rtl/sa_isa_pkg.sv
// ---------------------------------------------------------------------------
// sa_isa_pkg
// Instruction-set definitions shared by the instruction sequencer and the
// systolic-array decoder: opcode values, field widths, field bit ranges of the
// packed instruction word {opcode, addr, operand}, FSM state type and opcode
// classification helpers.
// ---------------------------------------------------------------------------
package sa_isa_pkg;

    localparam int OPCODE_W  = 4;
    localparam int ADDR_W    = 8;
    localparam int OPERAND_W = 128;
    localparam int LEN_W     = 9;
    localparam int GAP_W     = 8;
    localparam int INST_W    = OPCODE_W + ADDR_W + OPERAND_W;

    // Field bit ranges inside the instruction word (opcode in the MSBs)
    localparam int OPERAND_LSB = 0;
    localparam int OPERAND_MSB = OPERAND_W - 1;
    localparam int ADDR_LSB    = OPERAND_W;
    localparam int ADDR_MSB    = OPERAND_W + ADDR_W - 1;
    localparam int OPCODE_LSB  = OPERAND_W + ADDR_W;
    localparam int OPCODE_MSB  = INST_W - 1;

    localparam logic [OPCODE_W-1:0] OP_IDLE         = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LOAD_WEIGHT  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LOAD_DATA    = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_MAT_MUL      = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_READ_RESULT  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_WRITE_DATA   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_WRITE_WEIGHT = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_CLEAR        = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_ACCUMULATION = 4'h8;

    localparam logic [INST_W-1:0] IDLE_INST = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } seq_state_t;

    // Write opcodes carry an operand pulled from the operand stream
    function automatic logic is_write_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_WRITE_DATA) || (op == OP_WRITE_WEIGHT);
    endfunction

    // Only 0x1..0x8 may be sequenced; IDLE itself is not a command
    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return (op >= OP_LOAD_WEIGHT) && (op <= OP_ACCUMULATION);
    endfunction

endpackage

// File: rtl/sa_addr_gen.sv
// ---------------------------------------------------------------------------
// sa_addr_gen
// Loadable address / remaining-length counter for one instruction burst.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          capture addr_i/len_i/stride_i (start of a burst)
//   advance_i       step to the next address, one fewer instruction left
//   addr_i          first address
//   len_i           number of instructions in the burst
//   stride_i        address increment per instruction
//   addr_o          address of the current instruction
//   last_o          current instruction is the final one of the burst
// Addresses wrap naturally modulo 2**ADDR_BITS.
// ---------------------------------------------------------------------------
module sa_addr_gen #(
    parameter int ADDR_BITS = 8,
    parameter int LEN_BITS  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LEN_BITS-1:0]  len_i,
    input  logic [ADDR_BITS-1:0] stride_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 last_o
);

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] stride_q, stride_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;

    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        if (load_i) begin
            addr_d      = addr_i;
            stride_d    = stride_i;
            remaining_d = len_i;
        end else if (advance_i && (remaining_q != '0)) begin
            addr_d      = addr_q + stride_q;
            remaining_d = remaining_q - LEN_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (remaining_q == LEN_BITS'(1));

endmodule

// File: rtl/sa_inst_sequencer.sv
// ---------------------------------------------------------------------------
// sa_inst_sequencer
// Expands one command {opcode, addr, len, stride, gap} into a burst of
// registered instruction words {opcode, addr, operand}, followed by `gap`
// IDLE cycles. Write opcodes pull one operand per instruction from the
// op_valid/op_ready stream and insert IDLE bubbles while it stalls.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_opcode/addr/len/stride/gap   command fields
//   op_valid/ready/data operand stream (ready only while issuing writes)
//   instruction         registered instruction word, IDLE_INST when idle
//   busy                inverse of cmd_ready
//   done                one-cycle completion pulse
//   err                 one-cycle pulse with done for an illegal opcode
// ---------------------------------------------------------------------------
module sa_inst_sequencer
    import sa_isa_pkg::*;
#(
    parameter int OPCODE_BITS  = OPCODE_W,
    parameter int ADDR_BITS    = ADDR_W,
    parameter int OPERAND_BITS = OPERAND_W,
    parameter int LEN_BITS     = LEN_W,
    parameter int GAP_BITS     = GAP_W
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [OPCODE_BITS-1:0]                     cmd_opcode,
    input  logic [ADDR_BITS-1:0]                       cmd_addr,
    input  logic [LEN_BITS-1:0]                        cmd_len,
    input  logic [ADDR_BITS-1:0]                       cmd_stride,
    input  logic [GAP_BITS-1:0]                        cmd_gap,
    input  logic                                       op_valid,
    output logic                                       op_ready,
    input  logic [OPERAND_BITS-1:0]                    op_data,
    output logic [OPCODE_BITS+ADDR_BITS+OPERAND_BITS-1:0] instruction,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err
);

    localparam int IW = OPCODE_BITS + ADDR_BITS + OPERAND_BITS;

    seq_state_t               state_q, state_d;
    logic [OPCODE_BITS-1:0]   opcode_q, opcode_d;
    logic [GAP_BITS-1:0]      gap_q, gap_d;
    logic [IW-1:0]            inst_q, inst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     ag_load;
    logic                     ag_advance;
    logic [ADDR_BITS-1:0]     ag_addr;
    logic                     ag_last;
    logic                     write_op;

    sa_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ag_load),
        .advance_i (ag_advance),
        .addr_i    (cmd_addr),
        .len_i     (cmd_len),
        .stride_i  (cmd_stride),
        .addr_o    (ag_addr),
        .last_o    (ag_last)
    );

    assign write_op = is_write_op(opcode_q);

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        gap_d      = gap_q;
        inst_d     = '0;         // IDLE_INST unless an instruction issues
        done_d     = 1'b0;
        err_d      = 1'b0;
        ag_load    = 1'b0;
        ag_advance = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    gap_d    = cmd_gap;
                    ag_load  = 1'b1;
                    if (!is_legal_op(cmd_opcode)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Non-write opcodes never stall; writes wait for an operand
                if (!write_op || op_valid) begin
                    inst_d     = {opcode_q, ag_addr,
                                  write_op ? op_data : {OPERAND_BITS{1'b0}}};
                    ag_advance = 1'b1;
                    if (ag_last) begin
                        if (gap_q != '0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GAP_BITS'(1);
                if (gap_q == GAP_BITS'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            gap_q    <= '0;
            inst_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            gap_q    <= gap_d;
            inst_q   <= inst_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign op_ready    = (state_q == S_ISSUE) && write_op;
    assign instruction = inst_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_inst_sequencer
// Directed bench for the instruction sequencer: reset state, full write bursts
// with and without operand stalls, address wrap with trailing gap, zero-length
// and illegal commands, and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_sa_inst_sequencer;

    localparam int IW = 140;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_opcode;
    logic [7:0]      cmd_addr;
    logic [8:0]      cmd_len;
    logic [7:0]      cmd_stride;
    logic [7:0]      cmd_gap;
    logic            op_valid;
    logic            op_ready;
    logic [127:0]    op_data;
    logic [IW-1:0]   instruction;
    logic            busy;
    logic            done;
    logic            err;

    int tests_run    = 0;
    int tests_failed = 0;

    sa_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_stride  (cmd_stride),
        .cmd_gap     (cmd_gap),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_data     (op_data),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand for write word i: lane j holds (i - j) mod 256
    function automatic logic [127:0] operand(input int i);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(i - j);
        return v;
    endfunction

    // Offer a command for one edge; returns at the negedge after the accept edge
    task automatic issue(input logic [3:0] op, input logic [7:0] addr, input logic [8:0] len,
                         input logic [7:0] stride, input logic [7:0] gap);
        @(negedge clk);
        check("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_addr   = addr;
        cmd_len    = len;
        cmd_stride = stride;
        cmd_gap    = gap;
        @(negedge clk);
        cmd_valid  = 1'b0;
        $display("[TB] cmd op=%0h addr=%0h len=%0d stride=%0h gap=%0d", op, addr, len, stride, gap);
    endtask

    // Non-write burst with a legal opcode and len > 0
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] addr, input logic [8:0] len,
                           input logic [7:0] stride, input logic [7:0] gap);
        logic [7:0] a;
        logic       exp_done;
        issue(op, addr, len, stride, gap);
        check("lat_idle", instruction, '0);
        check("lat_busy", busy, 1'b1);
        a = addr;
        for (int i = 0; i < int'(len); i++) begin
            @(negedge clk);
            exp_done = (i == int'(len) - 1) && (gap == 8'd0);
            check("seq_word", instruction, {op, a, 128'h0});
            check("seq_op_ready", op_ready, 1'b0);
            check("seq_done", done, exp_done);
            check("seq_err", err, 1'b0);
            check("seq_busy", busy, !exp_done);
            a = a + stride;
        end
        for (int g = 0; g < int'(gap); g++) begin
            @(negedge clk);
            check("gap_word", instruction, '0);
            check("gap_op_ready", op_ready, 1'b0);
            check("gap_done", done, g == int'(gap) - 1);
        end
        @(negedge clk);
        check("post_done", done, 1'b0);
        check("post_ready", cmd_ready, 1'b1);
    endtask

    // WRITE_DATA addr 0 len 256 stride 1 gap 0; op_valid low when cyc%skip == skip-1
    task automatic run_write_burst(input int skip_every);
        int   sent;
        int   cyc;
        int   bubbles;
        logic fire;
        logic done_seen;
        issue(4'h5, 8'h00, 9'd256, 8'h01, 8'h00);
        sent = 0; cyc = 0; bubbles = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 1000) begin
            check("wr_op_ready", op_ready, sent < 256);
            op_valid = (skip_every == 0) || ((cyc % skip_every) != skip_every - 1);
            op_data  = operand(sent);
            fire     = op_valid && (sent < 256);
            @(negedge clk);
            cyc++;
            if (fire) begin
                check("wr_word", instruction, {4'h5, 8'(sent), operand(sent)});
                sent++;
            end else begin
                check("wr_bubble", instruction, '0);
                bubbles++;
            end
            check("wr_done", done, sent == 256);
            if (done) done_seen = 1'b1;
        end
        op_valid = 1'b0;
        check("wr_count", 140'(sent), 140'(256));
        check("wr_done_seen", done_seen, 1'b1);
        $display("[TB] write burst skip=%0d words=%0d bubbles=%0d cycles=%0d", skip_every, sent, bubbles, cyc);
        @(negedge clk);
        check("wr_post_done", done, 1'b0);
        check("wr_post_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_addr = '0; cmd_len = '0;
        cmd_stride = '0; cmd_gap = '0; op_valid = 1'b0; op_data = '0;

        // 1. reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst", instruction, '0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_op_ready", op_ready, 1'b0);
        $display("[TB] reset state checked");
        reset = 1'b0;

        // 2./3. full write bursts, free-running and stalled
        run_write_burst(0);
        run_write_burst(3);

        // 4. wrap with trailing gap; plus larger stride wrap and stride 0
        run_cmd(4'h1, 8'hFE, 9'd4, 8'h01, 8'd2);
        run_cmd(4'h3, 8'hF0, 9'd3, 8'h10, 8'd0);
        run_cmd(4'h8, 8'h33, 9'd3, 8'h00, 8'd1);

        // 5. zero-length and illegal commands
        issue(4'h3, 8'h10, 9'd0, 8'h01, 8'h00);
        check("len0_done", done, 1'b1);
        check("len0_err", err, 1'b0);
        check("len0_ready", cmd_ready, 1'b1);
        check("len0_inst", instruction, '0);
        @(negedge clk);
        check("len0_done_pulse", done, 1'b0);
        issue(4'hA, 8'h10, 9'd5, 8'h01, 8'h00);
        check("ill_done", done, 1'b1);
        check("ill_err", err, 1'b1);
        check("ill_inst", instruction, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ill_quiet_inst", instruction, '0);
            check("ill_quiet_done", done, 1'b0);
            check("ill_quiet_err", err, 1'b0);
            check("ill_quiet_ready", cmd_ready, 1'b1);
        end

        // 6. reset while instruction #10 of a WRITE_WEIGHT burst is visible
        issue(4'h6, 8'h00, 9'd20, 8'h01, 8'h00);
        for (int k = 0; k < 10; k++) begin
            op_valid = 1'b1;
            op_data  = operand(k);
            @(negedge clk);
            check("ww_word", instruction, {4'h6, 8'(k), operand(k)});
        end
        reset = 1'b1;
        op_data = operand(10);
        @(negedge clk);
        check("mid_rst_inst", instruction, '0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_op_ready", op_ready, 1'b0);
        reset = 1'b0;
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_done", done, 1'b0);
            check("after_rst_inst", instruction, '0);
        end
        $display("[TB] mid-burst reset checked");
        run_cmd(4'h3, 8'h00, 9'd4, 8'h01, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
